// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and defaults for the strided 2D scan sequencer.
package scan_pkg;

   localparam int SCAN_ADDR_W = 32;
   localparam int SCAN_CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } scan_state_t;

   typedef struct packed {
      logic [SCAN_ADDR_W-1:0] base;
      logic [SCAN_ADDR_W-1:0] x_stride;
      logic [SCAN_ADDR_W-1:0] y_stride;
      logic [SCAN_CNT_W-1:0]  x_count;
      logic [SCAN_CNT_W-1:0]  y_count;
   } scan_cfg_t;

endpackage

// File: rtl/scan_axis_cnt.sv
// rtl/scan_axis_cnt.sv - one scan axis index counter; wraps to zero after count-1.
module scan_axis_cnt
   import scan_pkg::*;
#(
   parameter int CNT_W = SCAN_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] count_i,
   output logic [CNT_W-1:0] idx_o,
   output logic             wrap_o
);

   logic [CNT_W-1:0] idx_q;
   logic [CNT_W-1:0] idx_d;

   assign wrap_o = (idx_q == count_i - CNT_W'(1));
   assign idx_o  = idx_q;

   always_comb begin
      idx_d = idx_q;
      if (clr_i) begin
         idx_d = '0;
      end else if (inc_i) begin
         idx_d = wrap_o ? '0 : idx_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - strided 2D address scan sequencer, x-major, valid/ready output.
// Optional addr_last output enabled by defining SCAN_CTRL_LAST_EN.
module scan_ctrl
   import scan_pkg::*;
#(
   parameter int ADDR_W = SCAN_ADDR_W,
   parameter int CNT_W  = SCAN_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_x_stride,
   input  logic [ADDR_W-1:0] cfg_y_stride,
   input  logic [CNT_W-1:0]  cfg_x_count,
   input  logic [CNT_W-1:0]  cfg_y_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] addr,
   output logic              addr_valid,
`ifdef SCAN_CTRL_LAST_EN
   output logic              addr_last,
`endif
   input  logic              addr_ready
);

   scan_state_t       state_q, state_d;
   scan_cfg_t         cfg_q, cfg_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] row_q, row_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;

   logic              accept;
   logic              cnt_clr;
   logic              x_inc, y_inc;
   logic              x_wrap, y_wrap;
   logic [CNT_W-1:0]  x_idx, y_idx;
   logic [CNT_W-1:0]  x_count, y_count;
   logic [ADDR_W-1:0] x_stride, y_stride;

`ifdef SCAN_CTRL_LAST_EN
   logic              last_q, last_d;
`endif

   assign x_count  = CNT_W'(cfg_q.x_count);
   assign y_count  = CNT_W'(cfg_q.y_count);
   assign x_stride = ADDR_W'(cfg_q.x_stride);
   assign y_stride = ADDR_W'(cfg_q.y_stride);
   assign accept   = valid_q & addr_ready;

   // The first beat address comes straight from cfg_base, so the latched base is kept only as a record.
   logic unused_cfg;
   assign unused_cfg = ^{cfg_q.base, x_idx, y_idx};

   scan_axis_cnt #(.CNT_W(CNT_W)) u_x_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (cnt_clr),
      .inc_i   (x_inc),
      .count_i (x_count),
      .idx_o   (x_idx),
      .wrap_o  (x_wrap)
   );

   scan_axis_cnt #(.CNT_W(CNT_W)) u_y_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (cnt_clr),
      .inc_i   (y_inc),
      .count_i (y_count),
      .idx_o   (y_idx),
      .wrap_o  (y_wrap)
   );

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      addr_d  = addr_q;
      row_d   = row_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      cnt_clr = 1'b0;
      x_inc   = 1'b0;
      y_inc   = 1'b0;
`ifdef SCAN_CTRL_LAST_EN
      last_d  = last_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               cfg_d.base     = SCAN_ADDR_W'(cfg_base);
               cfg_d.x_stride = SCAN_ADDR_W'(cfg_x_stride);
               cfg_d.y_stride = SCAN_ADDR_W'(cfg_y_stride);
               cfg_d.x_count  = SCAN_CNT_W'(cfg_x_count);
               cfg_d.y_count  = SCAN_CNT_W'(cfg_y_count);
               cnt_clr        = 1'b1;
               if (cfg_x_count == '0 || cfg_y_count == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
                  busy_d  = 1'b1;
                  valid_d = 1'b1;
                  addr_d  = cfg_base;
                  row_d   = cfg_base;
`ifdef SCAN_CTRL_LAST_EN
                  last_d  = (cfg_x_count == CNT_W'(1)) && (cfg_y_count == CNT_W'(1));
`endif
               end
            end
         end

         RUN: begin
            x_inc = accept;
            y_inc = accept & x_wrap;
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               valid_d = 1'b0;
`ifdef SCAN_CTRL_LAST_EN
               last_d  = 1'b0;
`endif
            end else if (accept) begin
               if (x_wrap && y_wrap) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  valid_d = 1'b0;
`ifdef SCAN_CTRL_LAST_EN
                  last_d  = 1'b0;
`endif
               end else if (x_wrap) begin
                  row_d  = row_q + y_stride;
                  addr_d = row_q + y_stride;
`ifdef SCAN_CTRL_LAST_EN
                  last_d = (x_count == CNT_W'(1)) && (y_idx + CNT_W'(1) == y_count - CNT_W'(1));
`endif
               end else begin
                  addr_d = addr_q + x_stride;
`ifdef SCAN_CTRL_LAST_EN
                  last_d = y_wrap && (x_idx + CNT_W'(1) == x_count - CNT_W'(1));
`endif
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cfg_q   <= '0;
         addr_q  <= '0;
         row_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         addr_q  <= addr_d;
         row_q   <= row_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

`ifdef SCAN_CTRL_LAST_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b0;
      end else begin
         last_q <= last_d;
      end
   end

   assign addr_last = last_q;
`endif

   assign busy       = busy_q;
   assign done       = done_q;
   assign addr       = addr_q;
   assign addr_valid = valid_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// tb/tb_scan_ctrl.sv - scoreboard bench for scan_ctrl with a nested-loop address model.
module tb_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        addr_ready = 1'b0;
   logic [31:0] cfg_base = '0;
   logic [31:0] cfg_x_stride = '0;
   logic [31:0] cfg_y_stride = '0;
   logic [15:0] cfg_x_count = '0;
   logic [15:0] cfg_y_count = '0;
   logic        busy, done, addr_valid;
   logic [31:0] addr;

   always #5 clk = ~clk;

   scan_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .cfg_base     (cfg_base),
      .cfg_x_stride (cfg_x_stride),
      .cfg_y_stride (cfg_y_stride),
      .cfg_x_count  (cfg_x_count),
      .cfg_y_count  (cfg_y_count),
      .busy         (busy),
      .done         (done),
      .addr         (addr),
      .addr_valid   (addr_valid),
      .addr_ready   (addr_ready)
   );

   typedef struct {
      logic [31:0] a;
      bit          last;
   } beat_t;

   beat_t       exp_q[$];
   beat_t       cur;
   int          vectors = 0;
   int          errors = 0;
   int          done_due = 0;
   bit          stall_prev = 0;
   bit          abort_prev = 0;
   logic [31:0] stall_addr = '0;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rdy(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (cyc % 3) == 0;
      return ($urandom % 3) != 0;
   endfunction

   // Monitor: compares every accepted beat, done pulse, stall and abort against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         done_due   = 0;
         stall_prev = 0;
         abort_prev = 0;
      end else begin
         if (abort_prev)
            check(!addr_valid && !busy, "abort_to_idle", {addr_valid, busy}, 0);
         if (stall_prev)
            check(addr_valid && addr == stall_addr, "stall_hold", {addr_valid, addr}, {1'b1, stall_addr});
         if (done_due > 0) begin
            done_due--;
            if (done_due == 0)
               check(done && !busy && !addr_valid, "done_pulse", {done, busy, addr_valid}, 3'b100);
         end else begin
            check(!done, "spurious_done", done, 0);
         end
         abort_prev = busy && abort;
         stall_prev = addr_valid && !addr_ready && !abort;
         stall_addr = addr;
         if (addr_valid && addr_ready) begin
            check(exp_q.size() != 0, "unexpected_beat", addr, 0);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               check(addr == cur.a, "beat_addr", addr, cur.a);
               if (cur.last && !abort) done_due = 1;
            end
         end
         if (abort_prev) exp_q.delete();
      end
   end

   task automatic run_scan(input logic [31:0] b, input logic [31:0] xs, input logic [31:0] ys,
                           input logic [15:0] xc, input logic [15:0] yc,
                           input int rmode, input int abort_k, input int rst_k, input bit hold);
      int guard;
      bit fin;
      guard = 0;
      while ((busy || done) && guard < 50) begin
         step();
         guard++;
      end
      if (xc != 0 && yc != 0) begin
         for (int y = 0; y < int'(yc); y++)
            for (int x = 0; x < int'(xc); x++)
               exp_q.push_back('{a: b + 32'(y) * ys + 32'(x) * xs,
                                 last: (x == int'(xc) - 1) && (y == int'(yc) - 1)});
      end else begin
         done_due = 2;
      end
      cfg_base     = b;
      cfg_x_stride = xs;
      cfg_y_stride = ys;
      cfg_x_count  = xc;
      cfg_y_count  = yc;
      start        = 1'b1;
      addr_ready   = rdy(rmode, 0);
      fin = 0;
      for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
         step();
         start        = hold && cyc >= 2 && cyc <= 4;
         cfg_base     = $urandom;
         cfg_x_stride = $urandom;
         cfg_y_stride = $urandom;
         cfg_x_count  = 16'($urandom);
         cfg_y_count  = 16'($urandom);
         abort        = (cyc == abort_k);
         addr_ready   = rdy(rmode, cyc);
         if (cyc == 1) begin
            if (xc != 0 && yc != 0)
               check(addr_valid && busy && addr == b, "first_beat", {addr_valid, busy, addr}, {2'b11, b});
            else
               check(!addr_valid && !busy, "zero_count_no_beat", {addr_valid, busy}, 0);
         end
         if (cyc == rst_k) begin
            rst = 1'b1;
            #1;
            check({busy, done, addr_valid, addr} == '0, "reset_mid_scan", {busy, done, addr_valid, addr}, 0);
            step();
            rst   = 1'b0;
            abort = 1'b0;
            start = 1'b0;
            fin   = 1;
         end else if (!abort && !start && exp_q.size() == 0 && done_due == 0 && !busy && !done) begin
            fin = 1;
         end
      end
      check(fin, "scan_timeout", fin, 1);
      if (!fin) begin
         exp_q.delete();
         done_due = 0;
      end
      start      = 1'b0;
      abort      = 1'b0;
      addr_ready = 1'b0;
   endtask

   initial begin
      #2;
      check({busy, done, addr_valid, addr} == '0, "reset_state", {busy, done, addr_valid, addr}, 0);
      step();
      rst = 1'b0;
      step();

      run_scan(32'h100, 32'h4, 32'h40, 16'd3, 16'd2, 0, 0, 0, 0);
      run_scan(32'h100, 32'h4, 32'h40, 16'd3, 16'd2, 1, 0, 0, 0);
      run_scan(32'h100, 32'h4, 32'h40, 16'd0, 16'd5, 0, 0, 0, 0);
      run_scan(32'hFFFF_FFF8, 32'h8, 32'h1234, 16'd2, 16'd1, 0, 0, 0, 0);
      run_scan(32'h100, 32'h4, 32'h40, 16'd3, 16'd2, 0, 3, 0, 0);
      run_scan(32'h100, 32'h4, 32'h40, 16'd3, 16'd2, 0, 0, 0, 0);
      run_scan(32'h200, 32'h10, 32'h100, 16'd3, 16'd2, 0, 0, 0, 1);
      run_scan(32'h300, 32'h4, 32'h40, 16'd3, 16'd2, 0, 0, 3, 0);
      run_scan(32'h100, 32'h4, 32'h40, 16'd3, 16'd2, 2, 0, 0, 0);
      run_scan(32'h500, 32'h0, 32'h0, 16'd2, 16'd2, 2, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         logic [31:0] b, xs, ys;
         logic [15:0] xc, yc;
         int ak;
         b  = $urandom;
         xs = ($urandom % 4 == 0) ? 32'h0 : $urandom;
         ys = ($urandom % 4 == 0) ? 32'h0 : $urandom;
         xc = 16'($urandom_range(0, 4));
         yc = 16'($urandom_range(0, 4));
         ak = ($urandom % 5 == 0) ? int'($urandom_range(1, 12)) : 0;
         run_scan(b, xs, ys, xc, yc, int'($urandom_range(0, 2)), ak, 0, 0);
      end

      repeat (3) step();
      check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/scan_ctrl.md
Name: scan_ctrl

Overview:
- Sequencer for the strided 2D address scan datapath.
- Accepts a one-cycle start command with a latched scan configuration.
- Emits one address per accepted beat over a valid/ready interface, x-major then y, and pulses done after the last beat.
- Sits between the host/config logic and the memory port that consumes scan addresses; supports abort and downstream back-pressure.

Parameters:
- ADDR_W, 32, width of base, strides and generated address.
- CNT_W, 16, width of x/y element counts and internal index counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin scan; sampled only in IDLE.
- abort  in  1  terminate scan; sampled only in RUN.
- cfg_base  in  ADDR_W  first address.
- cfg_x_stride  in  ADDR_W  increment between consecutive x elements.
- cfg_y_stride  in  ADDR_W  increment between row start addresses.
- cfg_x_count  in  CNT_W  elements per row.
- cfg_y_count  in  CNT_W  number of rows.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on scan completion.
- addr  out  ADDR_W  current address.
- addr_valid  out  1  addr is valid.
- addr_ready  in  1  consumer accepts addr when valid and ready are both high.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, addr_valid=0, addr=0; all indices and latched config cleared.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch all cfg_* inputs; cfg_* are ignored for the rest of the scan.
  - If either count is 0: go to DONE, emit no beats.
  - Otherwise: go to RUN; next cycle addr=cfg_base, addr_valid=1, busy=1, x_idx=0, y_idx=0, row_addr=cfg_base.
- RUN, beat accepted (addr_valid & addr_ready):
  - Not end of row (x_idx != x_count-1): x_idx+1, addr += x_stride.
  - End of row, not last row: x_idx=0, y_idx+1, row_addr += y_stride, addr = new row_addr.
  - Last beat (x_idx=x_count-1, y_idx=y_count-1): go to DONE; addr_valid=0 and busy=0 next cycle.
- RUN, no accept: addr and addr_valid hold stable; addr_valid never deasserts without an accept except on abort or reset.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE.
- Latency: start to first addr_valid = 1 cycle; last accept to done = 1 cycle.
- Throughput: one beat per cycle while addr_ready=1.
- Arithmetic:
  - All address sums are modulo 2^ADDR_W; wrap is silent.
  - Strides are unsigned; a stride of 0 repeats the address.
- Abort:
  - abort in RUN: IDLE next cycle; addr_valid=0, busy=0, no done pulse.
  - abort and accept in the same cycle: the beat counts as accepted, abort still wins, no done.
  - abort outside RUN is ignored.
- start outside IDLE is ignored, including in DONE.
- Reset mid-scan: immediate return to reset values; no done pulse.
- Outputs are all registered; there is no combinational path from addr_ready to any output.

Optional Feature:
- Macro: SCAN_CTRL_LAST_EN.
- Defined: adds output addr_last (1 bit, reset 0), high with addr_valid on the final beat (x_idx=x_count-1 and y_idx=y_count-1), registered with addr; abort clears it.
- Undefined: port absent; no last-beat logic.

Decomposition:
- scan_pkg holds:
  - scan_state_t enum {IDLE, RUN, DONE};
  - localparam defaults SCAN_ADDR_W=32, SCAN_CNT_W=16;
  - scan_cfg_t struct bundling base, strides and counts for the latched configuration.
- One sub-module, scan_axis_cnt:
  - CNT_W-bit index counter with inc, clear and count inputs;
  - outputs index and a wrap (at count-1) flag;
  - instantiated twice, for x and y, with the y increment gated by x wrap.

Test Plan:
- base=0x100, x_stride=4, y_stride=0x40, x_count=3, y_count=2, ready=1:
  - addrs 0x100, 0x104, 0x108, 0x140, 0x144, 0x148 on consecutive cycles;
  - done 1 cycle after last; busy low in the done cycle.
- Same config, ready toggling 1,0,0,1…: addr held stable during stalls; same 6-address sequence; done after 6th accept.
- x_count=0 with y_count=5 and start: no addr_valid ever; done pulse 1 cycle after start, then IDLE.
- base=0xFFFF_FFF8, x_stride=8, x_count=2, y_count=1: addrs 0xFFFF_FFF8 then 0x0000_0000 (wrap); done.
- abort asserted on 3rd beat of a 3x2 scan: addr_valid=0 next cycle, no done; new start then runs the full 6 beats.
- rst pulsed mid-scan, plus start held during RUN: all outputs 0 immediately on rst; the start during RUN has no effect on the sequence.
